key_note_select: RTL and testbench

KEY_NOTE_SELECT -- requirements
Module: key_note_select

---
 rtl/key_note_select.sv | 161 ++++++++++++++++
 tb/tb_key_note_select.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/key_note_select.sv
// Twelve-key note selector: synchronises and debounces the keys, picks the lowest pressed note and gates its tone to the speaker.
// Optional sustain (RELEASE hold after the last key lifts) is built when SUSTAIN_EN is defined.
module key_note_select #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RELEASE_CYCLES  = 12500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] keys,
  input  logic [11:0] tones,
  output logic        audio_out,
  output logic [3:0]  note_idx,
  output logic        note_valid
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_PLAY    = 2'd1;
  localparam logic [1:0]  ST_RELEASE = 2'd2;
  localparam logic [19:0] DEB_LAST   = 20'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time guard on the legal parameter ranges.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 1048575) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (RELEASE_CYCLES < 1 || RELEASE_CYCLES > 16777215) begin : g_bad_release
    $error("RELEASE_CYCLES out of range");
  end

  logic [11:0] sync1_q, sync2_q;
  logic [11:0] deb_q, deb_d;
  logic [19:0] cnt_q [12];
  logic [19:0] cnt_d [12];
  logic [1:0]  state_q, state_d;
  logic [3:0]  note_idx_q, note_idx_d;
  logic        note_valid_q, note_valid_d;
  logic        audio_q, audio_d;
  logic        any_key;
  logic [3:0]  sel_idx;
`ifdef SUSTAIN_EN
  localparam logic [23:0] REL_LOAD = 24'(RELEASE_CYCLES - 1);
  logic [23:0] rel_cnt_q, rel_cnt_d;
`endif

  // Per-key debounce: accept the synchronised level once it has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    for (int i = 0; i < 12; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = 20'd0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = 20'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 20'd1;
        end
      end else begin
        cnt_d[i] = 20'd0;
      end
    end
  end

  // Priority select: scanning downwards leaves the lowest pressed index.
  always_comb begin
    sel_idx = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (deb_q[i]) begin
        sel_idx = 4'(i);
      end else begin
        sel_idx = sel_idx;
      end
    end
    any_key = |deb_q;
  end

  // Note FSM plus next-cycle output values.
  always_comb begin
    state_d    = state_q;
    note_idx_d = note_idx_q;
`ifdef SUSTAIN_EN
    rel_cnt_d  = rel_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_key) begin
          state_d    = ST_PLAY;
          note_idx_d = sel_idx;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (any_key) begin
          note_idx_d = sel_idx;
        end else begin
`ifdef SUSTAIN_EN
          state_d    = ST_RELEASE;
          rel_cnt_d  = REL_LOAD;
`else
          state_d    = ST_IDLE;
`endif
        end
      end
`ifdef SUSTAIN_EN
      ST_RELEASE: begin
        // A press in the expiry cycle still wins over going idle.
        if (any_key) begin
          state_d    = ST_PLAY;
          note_idx_d = sel_idx;
        end else if (rel_cnt_q == 24'd0) begin
          state_d    = ST_IDLE;
        end else begin
          rel_cnt_d  = rel_cnt_q - 24'd1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    note_valid_d = (state_d != ST_IDLE);
    audio_d      = note_valid_q ? tones[note_idx_q] : 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 12'd0;
      sync2_q      <= 12'd0;
      deb_q        <= 12'd0;
      for (int i = 0; i < 12; i++) begin
        cnt_q[i] <= 20'd0;
      end
      state_q      <= ST_IDLE;
      note_idx_q   <= 4'd0;
      note_valid_q <= 1'b0;
      audio_q      <= 1'b0;
`ifdef SUSTAIN_EN
      rel_cnt_q    <= 24'd0;
`endif
    end else begin
      sync1_q      <= keys;
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      for (int i = 0; i < 12; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q      <= state_d;
      note_idx_q   <= note_idx_d;
      note_valid_q <= note_valid_d;
      audio_q      <= audio_d;
`ifdef SUSTAIN_EN
      rel_cnt_q    <= rel_cnt_d;
`endif
    end
  end

  assign audio_out  = audio_q;
  assign note_idx   = note_idx_q;
  assign note_valid = note_valid_q;

endmodule

// File: tb/tb_key_note_select.sv
// Directed bench for key_note_select (DEBOUNCE_CYCLES=4, RELEASE_CYCLES=8); expectations are queued per cycle and
// compared on the falling edge. Sustain-dependent expectations follow the SUSTAIN_EN macro.
module tb_key_note_select;

  logic        clk;
  logic        reset;
  logic [11:0] keys;
  logic [11:0] tones;
  logic        audio_out;
  logic [3:0]  note_idx;
  logic        note_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int c0;

  typedef struct {
    int         cyc;
    bit         aud;
    logic       v;
    logic [3:0] idx;
    string      tag;
  } ent_t;

  ent_t sb_q[$];

  key_note_select #(.DEBOUNCE_CYCLES(4), .RELEASE_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .keys       (keys),
    .tones      (tones),
    .audio_out  (audio_out),
    .note_idx   (note_idx),
    .note_valid (note_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input bit aud, input logic v, input logic [3:0] idx, input string tag);
    ent_t e;
    e.cyc = c; e.aud = aud; e.v = v; e.idx = idx; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // State (v,idx) expected at cycles from..to; audio one cycle later follows that state.
  task automatic exp_run(input string tag, input int from, input int to, input logic v, input logic [3:0] idx);
    for (int c = from; c <= to; c++) begin
      push(c, 1'b0, v, idx, tag);
      push(c + 1, 1'b1, v, idx, {tag, "_aud"});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard consumer and tone generator share the falling edge so tones stay fixed across each rising edge.
  initial begin
    logic [4:0]  obs_s, exp_s;
    logic        exp_a;
    tones = 12'h000;
    forever begin
      @(negedge clk);
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].cyc <= cyc) begin
          checks++;
          if (sb_q[i].cyc < cyc) begin
            assert (0) else begin
              errors++;
              $error("FAIL %s stale entry cyc=%0d now=%0d", sb_q[i].tag, sb_q[i].cyc, cyc);
            end
          end else if (sb_q[i].aud) begin
            exp_a = sb_q[i].v ? tones[sb_q[i].idx] : 1'b0;
            assert (audio_out === exp_a) else begin
              errors++;
              $error("FAIL %s cyc=%0d audio_out observed=%b expected=%b", sb_q[i].tag, cyc, audio_out, exp_a);
            end
          end else begin
            obs_s = {note_valid, note_idx};
            exp_s = {sb_q[i].v, sb_q[i].idx};
            assert (obs_s === exp_s) else begin
              errors++;
              $error("FAIL %s cyc=%0d valid/idx observed=%b/%0d expected=%b/%0d",
                     sb_q[i].tag, cyc, obs_s[4], obs_s[3:0], exp_s[4], exp_s[3:0]);
            end
          end
          sb_q.delete(i);
        end
      end
      tones = 12'($urandom);
    end
  end

  initial begin
    int budget;
    reset = 1'b1;
    keys  = 12'h000;
    @(negedge clk);
    c0 = cyc;
    exp_run("reset", c0 + 1, c0 + 2, 1'b0, 4'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Three-cycle glitch on key 5 must be ignored.
    c0 = cyc;
    keys = 12'h020;
    exp_run("glitch", c0 + 1, c0 + 10, 1'b0, 4'd0);
    tick(3);
    keys = 12'h000;
    tick(9);

    // Key 2: valid on the 7th edge after the change.
    c0 = cyc;
    keys = 12'h004;
    exp_run("pre_play2", c0 + 1, c0 + 6, 1'b0, 4'd0);
    exp_run("play2", c0 + 7, c0 + 12, 1'b1, 4'd2);
    tick(12);

    // Simultaneous 7 and 11 resolve to 7, then 11 after 7 lifts.
    c0 = cyc;
    keys = 12'h880;
    exp_run("hold2", c0 + 1, c0 + 6, 1'b1, 4'd2);
    exp_run("low7", c0 + 7, c0 + 10, 1'b1, 4'd7);
    tick(10);
    c0 = cyc;
    keys = 12'h800;
    exp_run("still7", c0 + 1, c0 + 6, 1'b1, 4'd7);
    exp_run("idx11", c0 + 7, c0 + 10, 1'b1, 4'd11);
    tick(10);

    // Release all keys.
    c0 = cyc;
    keys = 12'h000;
    exp_run("pre_rel", c0 + 1, c0 + 6, 1'b1, 4'd11);
`ifdef SUSTAIN_EN
    exp_run("release", c0 + 7, c0 + 14, 1'b1, 4'd11);
    exp_run("idle", c0 + 15, c0 + 18, 1'b0, 4'd11);
`else
    exp_run("idle", c0 + 7, c0 + 18, 1'b0, 4'd11);
`endif
    tick(18);

    // Press landing on the release expiry cycle.
    c0 = cyc;
    keys = 12'h002;
    exp_run("pre1", c0 + 1, c0 + 6, 1'b0, 4'd11);
    exp_run("play1", c0 + 7, c0 + 10, 1'b1, 4'd1);
    tick(10);
    c0 = cyc;
    keys = 12'h000;
`ifdef SUSTAIN_EN
    exp_run("rel1", c0 + 1, c0 + 14, 1'b1, 4'd1);
`else
    exp_run("rel1", c0 + 1, c0 + 6, 1'b1, 4'd1);
    exp_run("idle1", c0 + 7, c0 + 14, 1'b0, 4'd1);
`endif
    exp_run("press_wins", c0 + 15, c0 + 18, 1'b1, 4'd4);
    tick(8);
    keys = 12'h010;
    tick(10);

    // Reset in mid-release with key 3 held: full latency again afterwards.
    c0 = cyc;
    keys = 12'h000;
`ifdef SUSTAIN_EN
    exp_run("rel4", c0 + 1, c0 + 9, 1'b1, 4'd4);
    push(c0 + 10, 1'b0, 1'b1, 4'd4, "rel4_last");
`else
    exp_run("rel4", c0 + 1, c0 + 6, 1'b1, 4'd4);
    exp_run("idle4", c0 + 7, c0 + 9, 1'b0, 4'd4);
    push(c0 + 10, 1'b0, 1'b0, 4'd4, "idle4_last");
`endif
    push(c0 + 11, 1'b1, 1'b0, 4'd0, "rst_aud");
    exp_run("after_rst", c0 + 11, c0 + 17, 1'b0, 4'd0);
    exp_run("play3", c0 + 18, c0 + 21, 1'b1, 4'd3);
    tick(8);
    keys = 12'h008;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(10);

    budget = 0;
    while (sb_q.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL drain pending=%0d expected=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
